ram_port_arbiter: RTL

- Sits directly upstream of the per-node single-port word RAM and is the only block that drives its address, write-data and write-enable.
- Arbitrates between the local core load/store port and the NoC network-interface port, round-robin.
- Issues at most one access per cycle and returns read data using the RAM's fixed 1-cycle registered read latency.
- Suppresses out-of-range accesses and flags them.

---
 rtl/ram_arb_pkg.sv | 23 ++
 rtl/ram_port_arbiter_rr_arbiter2.sv | 40 ++++
 rtl/ram_port_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the RAM port arbiter slice.
//   port_id_e : requester identity (core / NoC), also the last_grant encoding
//   *_DEF     : default widths and RAM depth for ram_port_arbiter
//   STAT_W    : width of the optional statistics counters
//   sat_inc   : saturating increment for the statistics counters
package ram_arb_pkg;

  typedef enum logic {
    PORT_CORE = 1'b0,
    PORT_NOC  = 1'b1
  } port_id_e;

  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned ADDR_W_DEF   = 32;
  localparam int unsigned RAM_SIZE_DEF = 1024;
  localparam int unsigned STAT_W       = 16;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_arbiter2.sv
// Two-input round-robin arbiter.
//   clk, rst : clock and synchronous active-high reset
//   req[1:0] : request vector, bit 0 = core, bit 1 = NoC
//   accept   : the current grant was taken this cycle
//   gnt[1:0] : one-hot grant, combinational from req and last_grant
// On a conflict the port that did not win last time is granted; last_grant
// resets to PORT_NOC so the core wins the first conflict.
module rr_arbiter2
  import ram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  port_id_e last_grant;

  // History register: only moves when a grant is actually consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= PORT_NOC;
    end else if (accept) begin
      last_grant <= gnt[1] ? PORT_NOC : PORT_CORE;
    end
  end

  // Grant decode.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_grant == PORT_NOC) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbiter in front of a single-port word RAM with 1-cycle registered read.
// Serves the core and NoC request ports round-robin, one access per cycle,
// and returns a one-cycle response pulse the cycle after each accept.
//   clk, rst                  : clock, synchronous active-high reset
//   core_req_* / noc_req_*    : valid/ready request ports (we, addr, wdata)
//   core_rsp_* / noc_rsp_*    : response pulse and read data
//   ram_addr/ram_wr_data/ram_we, ram_rd_data : RAM interface
//   oob_err                   : sticky out-of-range access flag
// Optional (macro RAM_ARB_STATS_EN): core_grant_cnt, noc_grant_cnt,
// conflict_cnt saturating statistics counters.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned RAM_SIZE = RAM_SIZE_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req_valid,
  output logic              core_req_ready,
  input  logic              core_req_we,
  input  logic [ADDR_W-1:0] core_req_addr,
  input  logic [DATA_W-1:0] core_req_wdata,
  output logic              core_rsp_valid,
  output logic [DATA_W-1:0] core_rsp_rdata,
  input  logic              noc_req_valid,
  output logic              noc_req_ready,
  input  logic              noc_req_we,
  input  logic [ADDR_W-1:0] noc_req_addr,
  input  logic [DATA_W-1:0] noc_req_wdata,
  output logic              noc_rsp_valid,
  output logic [DATA_W-1:0] noc_rsp_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic              oob_err
`ifdef RAM_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] core_grant_cnt,
  output logic [STAT_W-1:0] noc_grant_cnt,
  output logic [STAT_W-1:0] conflict_cnt
`endif
);

  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              accept;
  logic              g_we;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;
  logic              in_range;

  // Requests are masked during reset so ready stays low and nothing is taken.
  assign req    = rst ? 2'b00 : {noc_req_valid, core_req_valid};
  assign accept = |gnt;

  rr_arbiter2 u_rr (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .accept (accept),
    .gnt    (gnt)
  );

  // Ready equals grant: a granted valid is always accepted the same cycle.
  assign core_req_ready = gnt[0];
  assign noc_req_ready  = gnt[1];

  // Granted request mux; all zero when idle.
  always_comb begin
    g_we    = 1'b0;
    g_addr  = '0;
    g_wdata = '0;
    if (gnt[0]) begin
      g_we    = core_req_we;
      g_addr  = core_req_addr;
      g_wdata = core_req_wdata;
    end else if (gnt[1]) begin
      g_we    = noc_req_we;
      g_addr  = noc_req_addr;
      g_wdata = noc_req_wdata;
    end
  end

  assign in_range    = g_addr < ADDR_W'(RAM_SIZE);
  assign ram_addr    = g_addr;
  assign ram_wr_data = g_wdata;
  assign ram_we      = accept && g_we && in_range;

  // Per-port response tracking; rd_ok marks an in-range read whose RAM data
  // is returned, everything else (writes, OOB reads) returns zero.
  logic core_pend_q, core_rd_ok_q;
  logic noc_pend_q,  noc_rd_ok_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      core_pend_q  <= 1'b0;
      core_rd_ok_q <= 1'b0;
      noc_pend_q   <= 1'b0;
      noc_rd_ok_q  <= 1'b0;
      oob_err      <= 1'b0;
    end else begin
      core_pend_q  <= gnt[0];
      core_rd_ok_q <= gnt[0] && !g_we && in_range;
      noc_pend_q   <= gnt[1];
      noc_rd_ok_q  <= gnt[1] && !g_we && in_range;
      if (accept && !in_range) begin
        oob_err <= 1'b1;
      end
    end
  end

  // A response pending when rst arrives is dropped, not delivered.
  assign core_rsp_valid = core_pend_q && !rst;
  assign noc_rsp_valid  = noc_pend_q && !rst;
  assign core_rsp_rdata = (core_rsp_valid && core_rd_ok_q) ? ram_rd_data : '0;
  assign noc_rsp_rdata  = (noc_rsp_valid && noc_rd_ok_q) ? ram_rd_data : '0;

`ifdef RAM_ARB_STATS_EN
  // Saturating grant and conflict statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      core_grant_cnt <= '0;
      noc_grant_cnt  <= '0;
      conflict_cnt   <= '0;
    end else begin
      if (gnt[0]) begin
        core_grant_cnt <= sat_inc(core_grant_cnt);
      end
      if (gnt[1]) begin
        noc_grant_cnt <= sat_inc(noc_grant_cnt);
      end
      if (req == 2'b11) begin
        conflict_cnt <= sat_inc(conflict_cnt);
      end
    end
  end
`endif

endmodule
